// File: rtl/alu_cmd_issuer.sv
// ============================================================================
// Module   : alu_cmd_issuer (with alu_types_pkg)
// Brief    : Credit-based command issuer for a fixed-latency, non-stalling ALU.
//            Accepts tagged commands, drives the ALU, captures results in issue
//            order and presents them with their tag/op under backpressure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_types_pkg;
    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_RSVD = 2'd3
    } operation_t;
endpackage

module alu_cmd_issuer
    import alu_types_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int TAG_W = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    // command side
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  operation_t       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    // ALU side
    output operation_t       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_in_valid,
    input  logic [WIDTH:0]   alu_out,
    input  logic             alu_out_valid,
    // response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_data,
    output operation_t       rsp_op,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             err_unexpected
);

    // Pointers carry one extra wrap bit so that "all slots allocated" and
    // "nothing outstanding" stay distinguishable.
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [c_ptr_w:0]   r_alloc_ptr;
    logic [c_ptr_w:0]   r_fill_ptr;
    logic [c_ptr_w:0]   r_rd_ptr;
    logic [c_ptr_w:0]   w_count;
    logic [c_ptr_w-1:0] w_alloc_idx;
    logic [c_ptr_w-1:0] w_fill_idx;
    logic [c_ptr_w-1:0] w_rd_idx;

    operation_t         r_op   [DEPTH];
    logic [TAG_W-1:0]   r_tag  [DEPTH];
    logic [WIDTH:0]     r_data [DEPTH];
    logic [DEPTH-1:0]   r_filled;

    logic               r_run;
    logic               r_err;
    operation_t         r_alu_op;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic               r_alu_in_valid;

    logic               w_accept;
    logic               w_retire;
    logic               w_outstanding;
    logic               w_capture;
    logic               w_unexpected;

    assign w_alloc_idx   = r_alloc_ptr[c_ptr_w-1:0];
    assign w_fill_idx    = r_fill_ptr[c_ptr_w-1:0];
    assign w_rd_idx      = r_rd_ptr[c_ptr_w-1:0];

    // Entries allocated but not yet retired.
    assign w_count       = r_alloc_ptr - r_rd_ptr;

    // DEPTH is a power of two, so the top bit of the count marks "full".
    // r_run keeps ready low while in reset and until the first edge after it.
    assign cmd_ready     = r_run && !w_count[c_ptr_w];

    assign w_accept      = cmd_valid && cmd_ready;
    assign w_retire      = rsp_valid && rsp_ready;

    // A result only belongs to us if an issued command is still unfilled.
    assign w_outstanding = (r_fill_ptr != r_alloc_ptr);
    assign w_capture     = alu_out_valid && w_outstanding;
    assign w_unexpected  = alu_out_valid && !w_outstanding;

    assign rsp_valid     = r_filled[w_rd_idx];
    assign rsp_data      = r_data[w_rd_idx];
    assign rsp_op        = r_op[w_rd_idx];
    assign rsp_tag       = r_tag[w_rd_idx];

    assign alu_op        = r_alu_op;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_in_valid  = r_alu_in_valid;
    assign err_unexpected = r_err;

    // Register the ALU drive: one-cycle valid pulse per accepted command,
    // operands held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_in_valid <= 1'b0;
            r_alu_op       <= operation_t'(2'd0);
            r_alu_a        <= '0;
            r_alu_b        <= '0;
        end else begin
            r_alu_in_valid <= w_accept;
            if (w_accept) begin
                r_alu_op <= cmd_op;
                r_alu_a  <= cmd_a;
                r_alu_b  <= cmd_b;
            end
        end
    end

    // Pointer advance, run flag and sticky unexpected-result flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_run       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_alloc_ptr <= r_alloc_ptr + 1'b1;
            end
            if (w_capture) begin
                r_fill_ptr <= r_fill_ptr + 1'b1;
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_unexpected) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entry storage: allocate on accept, fill on ALU result, clear on retire.
    // The three indices never collide on the same entry in one cycle because
    // accept is blocked when full and only filled entries can retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i]   <= operation_t'(2'd0);
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            r_filled <= '0;
        end else begin
            if (w_accept) begin
                r_op[w_alloc_idx]     <= cmd_op;
                r_tag[w_alloc_idx]    <= cmd_tag;
                r_filled[w_alloc_idx] <= 1'b0;
            end
            if (w_capture) begin
                r_data[w_fill_idx]   <= alu_out;
                r_filled[w_fill_idx] <= 1'b1;
            end
            if (w_retire) begin
                r_filled[w_rd_idx] <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
// ============================================================================
// Module   : tb_alu_cmd_issuer
// Brief    : Self-checking bench for alu_cmd_issuer with an attached 2-cycle
//            ALU and a queue-based expected-response model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_issuer;
    import alu_types_pkg::*;

    localparam int WIDTH = 6;
    localparam int TAG_W = 4;
    localparam int DEPTH = 8;

    typedef struct packed {
        operation_t       op;
        logic [TAG_W-1:0] tag;
        logic [WIDTH:0]   data;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    operation_t       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    operation_t       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_in_valid;
    logic [WIDTH:0]   alu_out;
    logic             alu_out_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH:0]   rsp_data;
    operation_t       rsp_op;
    logic [TAG_W-1:0] rsp_tag;
    logic             err_unexpected;

    int   n_checks;
    int   n_errors;
    logic mon_en;
    logic inject;
    exp_t mq[$];
    exp_t m_e;
    int   got;

    alu_cmd_issuer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_tag        (cmd_tag),
        .alu_op         (alu_op),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_in_valid   (alu_in_valid),
        .alu_out        (alu_out),
        .alu_out_valid  (alu_out_valid),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_op         (rsp_op),
        .rsp_tag        (rsp_tag),
        .err_unexpected (err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- attached ALU: latency 2, shares rst ----------------
    logic             s1_v;
    operation_t       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_v;
    logic [WIDTH:0]   s2_res;

    function automatic logic [WIDTH:0] alu_calc(operation_t op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = a * b;
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_MUL:  return p[WIDTH:0];
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_op  <= OP_ADD;
            s1_a   <= '0;
            s1_b   <= '0;
            s2_v   <= 1'b0;
            s2_res <= '0;
        end else begin
            s1_v   <= alu_in_valid;
            s1_op  <= alu_op;
            s1_a   <= alu_a;
            s1_b   <= alu_b;
            s2_v   <= s1_v;
            s2_res <= alu_calc(s1_op, s1_a, s1_b);
        end
    end

    assign alu_out       = s2_res;
    assign alu_out_valid = s2_v | inject;

    // ---------------- reference model: result from plain arithmetic -------
    function automatic logic [WIDTH:0] ref_result(operation_t op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        int r;
        case (op)
            OP_ADD:  r = int'(a) + int'(b);
            OP_SUB:  r = int'(a) - int'(b) + 128;
            OP_MUL:  r = int'(a) * int'(b);
            default: r = 0;
        endcase
        return (WIDTH+1)'(r % 128);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Sampled at negedge: ready vs model occupancy, response vs queue head.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("cmd_ready_model", 32'(cmd_ready), 32'(mq.size() < DEPTH));
            if (rsp_valid) begin
                if (mq.size() == 0) begin
                    check("rsp_spurious", 32'(rsp_valid), 32'd0);
                end else begin
                    check("rsp_data", 32'(rsp_data), 32'(mq[0].data));
                    check("rsp_tag",  32'(rsp_tag),  32'(mq[0].tag));
                    check("rsp_op",   32'(rsp_op),   32'(mq[0].op));
                    if (rsp_ready) void'(mq.pop_front());
                end
            end
            if (cmd_valid && cmd_ready) begin
                m_e.op   = cmd_op;
                m_e.tag  = cmd_tag;
                m_e.data = ref_result(cmd_op, cmd_a, cmd_b);
                mq.push_back(m_e);
            end
        end
    end

    task automatic new_payload(input int opsel);
        if (opsel < 0) cmd_op = operation_t'(2'($urandom_range(0, 3)));
        else           cmd_op = operation_t'(2'(opsel));
        cmd_a   = WIDTH'($urandom);
        cmd_b   = WIDTH'($urandom);
        cmd_tag = TAG_W'($urandom);
    endtask

    // Offer commands until n are accepted or the cycle budget runs out.
    // Called and returns at 1 time unit after a rising edge.
    task automatic push_stream(input int n, input int budget, input int opsel, output int acc_cnt);
        int   cyc;
        logic acc;
        acc_cnt = 0;
        cyc     = 0;
        new_payload(opsel);
        cmd_valid = 1'b1;
        while (acc_cnt < n && cyc < budget) begin
            acc = cmd_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cnt++;
                new_payload(opsel);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("drained", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b0;
        inject    = 1'b0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_ADD;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b1;

        // ---- reset and release ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rel_alu_in_valid", 32'(alu_in_valid), 32'd0);
        check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rel_err", 32'(err_unexpected), 32'd0);

        // ---- single add 63+63 tag 3, latency 3 ----
        cmd_op = OP_ADD; cmd_a = 6'd63; cmd_b = 6'd63; cmd_tag = 4'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;                       // edge 0: accept
        cmd_valid = 1'b0;
        check("add_in_valid_hi", 32'(alu_in_valid), 32'd1);
        check("add_alu_a", 32'(alu_a), 32'd63);
        check("add_alu_op", 32'(alu_op), 32'(OP_ADD));
        @(posedge clk); #1;                       // edge 1
        check("add_in_valid_lo", 32'(alu_in_valid), 32'd0);
        check("add_alu_a_hold", 32'(alu_a), 32'd63);
        @(posedge clk); #1;                       // edge 2
        check("add_rsp_early", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;                       // edge 3
        check("add_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_rsp_data", 32'(rsp_data), 32'h7E);
        check("add_rsp_tag", 32'(rsp_tag), 32'd3);
        drain();

        // ---- back-to-back sub/mul/add ----
        cmd_op = OP_SUB; cmd_a = 6'd10; cmd_b = 6'd4; cmd_tag = 4'd1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b_ready0", 32'(cmd_ready), 32'd1);
        cmd_op = OP_MUL; cmd_a = 6'd63; cmd_b = 6'd63; cmd_tag = 4'd2;
        @(posedge clk); #1;
        check("b2b_ready1", 32'(cmd_ready), 32'd1);
        cmd_op = OP_ADD; cmd_a = 6'd5; cmd_b = 6'd3; cmd_tag = 4'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_v1", 32'(rsp_valid), 32'd1);
        check("b2b_t1", 32'(rsp_tag), 32'd1);
        check("b2b_d1", 32'(rsp_data), 32'd6);
        @(posedge clk); #1;
        check("b2b_v2", 32'(rsp_valid), 32'd1);
        check("b2b_t2", 32'(rsp_tag), 32'd2);
        check("b2b_d2", 32'(rsp_data), 32'd1);
        @(posedge clk); #1;
        check("b2b_v3", 32'(rsp_valid), 32'd1);
        check("b2b_t3", 32'(rsp_tag), 32'd3);
        check("b2b_d3", 32'(rsp_data), 32'd8);
        drain();

        // ---- backpressure: 10 adds against rsp_ready=0 ----
        rsp_ready = 1'b0;
        push_stream(10, 14, int'(OP_ADD), got);
        check("bp_accepted", 32'(got), 32'd8);
        check("bp_full_ready", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_rerise", 32'(cmd_ready), 32'd1);
        push_stream(2, 20, int'(OP_ADD), got);
        check("bp_rest_accepted", 32'(got), 32'd2);
        drain();

        // ---- unexpected result with nothing outstanding ----
        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        check("unexp_err", 32'(err_unexpected), 32'd1);
        check("unexp_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("unexp_err_sticky", 32'(err_unexpected), 32'd1);
        push_stream(1, 5, -1, got);
        check("unexp_next_acc", 32'(got), 32'd1);
        drain();

        // ---- random traffic with random backpressure ----
        fork
            begin
                push_stream(40, 400, -1, got);
            end
            begin
                repeat (120) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        check("rand_accepted", 32'(got), 32'd40);
        drain();
        check("rand_err_sticky", 32'(err_unexpected), 32'd1);

        // ---- reset while commands are in flight ----
        push_stream(3, 10, -1, got);
        @(posedge clk); #1;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        mq.delete();
        check("mrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mrst_alu_in_valid", 32'(alu_in_valid), 32'd0);
        check("mrst_alu_a", 32'(alu_a), 32'd0);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst_rsp_data", 32'(rsp_data), 32'd0);
        check("mrst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("mrst_err", 32'(err_unexpected), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        check("mrst_rel_ready", 32'(cmd_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("mrst_no_stale", 32'(rsp_valid), 32'd0);
        push_stream(1, 5, -1, got);
        check("mrst_new_acc", 32'(got), 32'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
